layer0_input_quantizer: RTL and testbench
=========================================

// Module: layer0_input_quantizer
// PURPOSE
//  Streaming front end for the layer-0 neuron LUTs. Accepts one raw signed feature per beat,
//  quantizes each to a 2-bit code against per-feature thresholds, and packs a full frame into one
//  vector. Presents that vector to the layer-0 fan-out with valid/ready; double-buffered.
// PARAMETERS
//  NUM_FEATURES  32     features per frame (>=2); out_data width = NUM_FEATURES*CODE_W
//  IN_W          16     raw feature width, two's complement
//  CODE_W        2      code width per feature (fixed 2: three thresholds)
//  THRESH        '0     flat vector, NUM_FEATURES*3*IN_W; feature f thr k at [(f*3+k)*IN_W +: IN_W]
// PORTS
//  clk        in   1                 rising-edge clock
//  rst_n      in   1                 asynchronous active-low reset
//  in_valid   in   1                 raw feature beat valid
//  in_ready   out  1                 block can accept beat
//  in_data    in   IN_W              raw feature, signed
//  in_last    in   1                 marks final beat of frame
//  out_valid  out  1                 packed frame valid
//  out_ready  in   1                 layer-0 consumer accepts
//  out_data   out  NUM_FEATURES*2    code f at [2f+1:2f]
//  frame_err  out  1                 one-cycle pulse: frame length mismatch, frame dropped
// BEHAVIOUR
//  - Reset: out_valid=0, out_data=0, frame_err=0, in_ready=1, feature counter=0, state COLLECT.
//  - Beat accepted when in_valid&&in_ready. Code = 0 if x<T0; 1 if T0<=x<T1; 2 if T1<=x<T2; else 3.
//    Signed compares; THRESH must be ascending per feature (T0<=T1<=T2), not checked in RTL.
//  - Accepted beat idx f writes code into collect reg slot f; counter increments.
//  - Frame end: beat with idx NUM_FEATURES-1 AND in_last=1 -> frame complete.
//  - Errors (frame_err pulses next cycle, collect reg discarded, counter->0, nothing emitted):
//    in_last=1 at idx < NUM_FEATURES-1 (short); in_last=0 at idx NUM_FEATURES-1 (long, the
//    remaining beats through the next in_last are then dropped in state DRAIN, in_ready=1).
//  - States: COLLECT (accepting), DRAIN (discard until in_last beat, then COLLECT),
//    STALL (complete frame held in collect reg because output reg occupied; in_ready=0).
//  - Transfer collect->output reg on the cycle after completion if output empty or being emptied
//    same cycle (out_valid&&out_ready); else enter STALL, leave STALL on first out_ready.
//  - Latency: last beat accepted at cycle N -> out_valid=1 at N+1 (output free). Back-to-back
//    frames sustain 1 beat/cycle with out_ready held high.
//  - out_data stable while out_valid&&!out_ready. out_valid drops cycle after handshake unless a
//    new frame loads same cycle.
//  - in_ready combinational only on state (not on in_valid); no combinational in->out path.
//  - Async reset mid-frame: partial frame discarded, all state as above; no output glitch after
//    deassertion (deassertion synchronised externally).
// STRUCTURE
//  - Shared package logicnet_pkg: CODE_W, feature-count and threshold localparams emitted by the
//    toolflow, state enum {COLLECT, DRAIN, STALL}.
//  - One sub-module: feature_quantizer (pure combinational, one IN_W value + 3 thresholds ->
//    2-bit code), instantiated once; threshold slice muxed by feature counter.
//  - Top holds counter, FSM, collect reg, output reg.
// TESTING
//  - NUM_FEATURES=4, IN_W=8, thr (-10,0,10) all features; send -11,-10,9,10 last on 4th, ready=1
//    -> out_data=8'b11_10_01_00, out_valid 1 cycle after last beat.
//  - Same frame twice back-to-back, out_ready=0 -> 2nd frame STALLs, in_ready=0; raise ready ->
//    frame 1 then frame 2 emitted in order, data stable while held.
//  - 3 beats with last on 3rd -> frame_err pulse, no out_valid; next good frame emitted correctly.
//  - 6 beats, last on 6th -> frame_err, beats 5-6 drained, following good frame correct.
//  - rst_n low after 2 beats -> all outputs reset; fresh 4-beat frame emits only its own codes.
//  - Random beats/valid/ready gaps vs. reference model; scoreboard checks every code, no loss/dup.

Source files
------------

// File: rtl/logicnet_pkg.sv
// Shared definitions for the LogicNet layer-0 front end: code width, default frame geometry
// and the frame-collection state encoding.
package logicnet_pkg;

    localparam int CODE_W           = 2;
    localparam int NUM_THRESH       = 3;
    localparam int NUM_FEATURES_DEF = 32;
    localparam int IN_W_DEF         = 16;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        DRAIN   = 2'd1,
        STALL   = 2'd2
    } qstate_e;

endpackage

// File: rtl/feature_quantizer.sv
// Maps one signed raw feature onto a 2-bit code using three ascending signed thresholds.
module feature_quantizer
    import logicnet_pkg::*;
#(
    parameter int IN_W = IN_W_DEF
) (
    input  logic signed [IN_W-1:0]   x,
    input  logic signed [IN_W-1:0]   thr0,
    input  logic signed [IN_W-1:0]   thr1,
    input  logic signed [IN_W-1:0]   thr2,
    output logic        [CODE_W-1:0] code
);

    // Priority compare: the first threshold the value falls below picks the code.
    always_comb begin
        if (x < thr0) begin
            code = 2'd0;
        end else if (x < thr1) begin
            code = 2'd1;
        end else if (x < thr2) begin
            code = 2'd2;
        end else begin
            code = 2'd3;
        end
    end

endmodule

// File: rtl/layer0_input_quantizer.sv
// Streams raw features in, quantizes each against its own thresholds, and hands complete
// frames to the layer-0 fan-out through a collect register backed by an output register.
module layer0_input_quantizer
    import logicnet_pkg::*;
#(
    parameter int                                NUM_FEATURES = NUM_FEATURES_DEF,
    parameter int                                IN_W         = IN_W_DEF,
    parameter logic [NUM_FEATURES*3*IN_W-1:0]    THRESH       = '0
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [IN_W-1:0]                  in_data,
    input  logic                             in_last,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [NUM_FEATURES*CODE_W-1:0]   out_data,
    output logic                             frame_err
);

    localparam int                 CNT_W    = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;
    localparam int                 FRAME_W  = NUM_FEATURES * CODE_W;
    localparam logic [CNT_W-1:0]   LAST_IDX = CNT_W'(NUM_FEATURES - 1);

    qstate_e                  state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [FRAME_W-1:0]       collect_q, collect_d;
    logic [FRAME_W-1:0]       out_data_q, out_data_d;
    logic                     out_valid_q, out_valid_d;
    logic                     frame_err_q, frame_err_d;

    logic [CODE_W-1:0]        code_s;
    logic [FRAME_W-1:0]       frame_s;
    logic                     accept_s;
    logic                     out_free_s;
    logic signed [IN_W-1:0]   thr_tab_s [NUM_FEATURES][NUM_THRESH];

    for (genvar f = 0; f < NUM_FEATURES; f++) begin : g_feat
        for (genvar k = 0; k < NUM_THRESH; k++) begin : g_thr
            assign thr_tab_s[f][k] = THRESH[(f*NUM_THRESH+k)*IN_W +: IN_W];
        end
    end

    // The single quantizer is time-shared; its thresholds follow the feature counter.
    feature_quantizer #(
        .IN_W (IN_W)
    ) u_quant (
        .x    (in_data),
        .thr0 (thr_tab_s[cnt_q][0]),
        .thr1 (thr_tab_s[cnt_q][1]),
        .thr2 (thr_tab_s[cnt_q][2]),
        .code (code_s)
    );

    assign in_ready   = (state_q != STALL);
    assign accept_s   = in_valid && in_ready;
    assign out_free_s = !out_valid_q || out_ready;

    // Collect register with the current beat's code merged into its slot.
    always_comb begin
        frame_s = collect_q;
        for (int f = 0; f < NUM_FEATURES; f++) begin
            if (cnt_q == CNT_W'(f)) begin
                frame_s[f*CODE_W +: CODE_W] = code_s;
            end else begin
                frame_s[f*CODE_W +: CODE_W] = collect_q[f*CODE_W +: CODE_W];
            end
        end
    end

    // Next-state logic for the frame FSM, collect register and output register.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        collect_d   = collect_q;
        out_data_d  = out_data_q;
        frame_err_d = 1'b0;
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        case (state_q)
            COLLECT: begin
                if (accept_s) begin
                    if (cnt_q == LAST_IDX) begin
                        cnt_d     = '0;
                        collect_d = '0;
                        if (!in_last) begin
                            frame_err_d = 1'b1;
                            state_d     = DRAIN;
                        end else if (out_free_s) begin
                            // Complete frame bypasses the collect register straight to the output.
                            out_valid_d = 1'b1;
                            out_data_d  = frame_s;
                        end else begin
                            collect_d = frame_s;
                            state_d   = STALL;
                        end
                    end else if (in_last) begin
                        frame_err_d = 1'b1;
                        cnt_d       = '0;
                        collect_d   = '0;
                    end else begin
                        collect_d = frame_s;
                        cnt_d     = cnt_q + CNT_W'(1);
                    end
                end else begin
                    state_d = COLLECT;
                end
            end
            DRAIN: begin
                if (accept_s && in_last) begin
                    state_d = COLLECT;
                end else begin
                    state_d = DRAIN;
                end
            end
            STALL: begin
                // Output is necessarily occupied here, so out_ready means it empties this cycle.
                if (out_ready) begin
                    out_valid_d = 1'b1;
                    out_data_d  = collect_q;
                    collect_d   = '0;
                    state_d     = COLLECT;
                end else begin
                    state_d = STALL;
                end
            end
            default: begin
                state_d   = COLLECT;
                cnt_d     = '0;
                collect_d = '0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= COLLECT;
            cnt_q       <= '0;
            collect_q   <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            collect_q   <= collect_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_layer0_input_quantizer.sv
// Directed and randomized checks of layer0_input_quantizer (4 features, 8-bit, thresholds -10/0/10)
// against a frame-level reference model and an in-order scoreboard.
module tb_layer0_input_quantizer;

    localparam int NF = 4;
    localparam int IW = 8;
    localparam logic [NF*3*IW-1:0] TB_THRESH = {4{24'h0A00F6}};

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [IW-1:0]  in_data;
    logic           in_last;
    logic           out_valid;
    logic           out_ready;
    logic [NF*2-1:0] out_data;
    logic           frame_err;

    int checks = 0;
    int errors = 0;

    int          tthr [NF][3];
    int          beats_m [$];
    logic [7:0]  exp_q [$];
    bit          drain_m;
    logic        exp_err;
    bit          held;
    logic [7:0]  held_data;
    logic        last_acc;
    bit          rand_ready;

    layer0_input_quantizer #(
        .NUM_FEATURES (NF),
        .IN_W         (IW),
        .THRESH       (TB_THRESH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic int qref(input int x, input int f);
        if (x < tthr[f][0]) return 0;
        if (x < tthr[f][1]) return 1;
        if (x < tthr[f][2]) return 2;
        return 3;
    endfunction

    function automatic logic [7:0] pack_frame();
        logic [7:0] p = 8'd0;
        for (int f = 0; f < NF; f++) p = p | (8'(qref(beats_m[f], f)) << (2 * f));
        return p;
    endfunction

    // Frame-level rules: complete frames are queued, wrong lengths flag an error.
    task automatic model_beat(input int x, input logic lst);
        if (drain_m) begin
            if (lst) drain_m = 1'b0;
        end else begin
            beats_m.push_back(x);
            if (lst) begin
                if (beats_m.size() == NF) exp_q.push_back(pack_frame());
                else exp_err = 1'b1;
                beats_m.delete();
            end else if (beats_m.size() == NF) begin
                exp_err = 1'b1;
                drain_m = 1'b1;
                beats_m.delete();
            end
        end
    endtask

    task automatic model_reset();
        beats_m.delete();
        exp_q.delete();
        drain_m = 1'b0;
        exp_err = 1'b0;
        held    = 1'b0;
    endtask

    // One clock: check outputs at the falling edge, then advance the model past the rising edge.
    task automatic tick();
        logic acc, lst;
        logic [7:0] dat;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        chk("frame_err", frame_err, exp_err);
        if (held) begin
            chk("hold_valid", out_valid, 1'b1);
            chk("hold_data", out_data, held_data);
        end
        if (out_valid && out_ready) begin
            chk("sb_nonempty", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) chk("frame_data", out_data, exp_q.pop_front());
        end
        held      = out_valid && !out_ready;
        held_data = out_data;
        acc = in_valid && in_ready;
        lst = in_last;
        dat = in_data;
        @(posedge clk);
        #1;
        last_acc = acc;
        exp_err  = 1'b0;
        if (acc) model_beat(int'($signed(dat)), lst);
    endtask

    task automatic send_beat(input int v, input logic lst);
        int n = 0;
        in_valid = 1'b1;
        in_data  = 8'(v);
        in_last  = lst;
        last_acc = 1'b0;
        while (!last_acc && n < 200) begin
            tick();
            n++;
        end
        chk("beat_accept", last_acc, 1'b1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_last  = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_frame(input int a, input int b, input int c, input int d);
        send_beat(a, 1'b0);
        send_beat(b, 1'b0);
        send_beat(c, 1'b0);
        send_beat(d, 1'b1);
    endtask

    initial begin
        int picks [8] = '{-11, -10, -1, 0, 9, 10, -128, 127};
        for (int f = 0; f < NF; f++) begin
            tthr[f][0] = -10;
            tthr[f][1] = 0;
            tthr[f][2] = 10;
        end
        rand_ready = 1'b0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_data    = 8'd0;
        in_last    = 1'b0;
        out_ready  = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 8'h00);
        chk("rst_frame_err", frame_err, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic frame: codes 0,1,2,3 at the threshold boundaries, one-cycle latency.
        send_frame(-11, -10, 9, 10);
        chk("lat_valid", out_valid, 1'b1);
        chk("lat_data", out_data, 8'b11_10_01_00);
        idle(3);

        // Two frames with consumer blocked: second frame stalls, then both drain in order.
        out_ready = 1'b0;
        send_frame(-11, -10, 9, 10);
        send_frame(10, 9, -10, -11);
        chk("stall_in_ready", in_ready, 1'b0);
        chk("stall_data", out_data, 8'hE4);
        idle(4);
        out_ready = 1'b1;
        tick();
        chk("stall_second", out_data, 8'h1B);
        idle(3);
        chk("stall_release_ready", in_ready, 1'b1);

        // Short frame.
        send_beat(1, 1'b0);
        send_beat(2, 1'b0);
        send_beat(3, 1'b1);
        chk("short_err_pulse", frame_err, 1'b1);
        idle(1);
        send_frame(0, 5, -50, 100);
        idle(3);

        // Long frame: beats 5 and 6 drained.
        for (int i = 0; i < 6; i++) send_beat(i * 7 - 20, (i == 5));
        idle(1);
        send_frame(127, -128, 0, -1);
        idle(3);

        // Reset mid-frame.
        send_beat(20, 1'b0);
        send_beat(-20, 1'b0);
        rst_n = 1'b0;
        model_reset();
        #2;
        chk("mid_rst_out_valid", out_valid, 1'b0);
        chk("mid_rst_out_data", out_data, 8'h00);
        chk("mid_rst_frame_err", frame_err, 1'b0);
        chk("mid_rst_in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_frame(9, 10, -10, -11);
        chk("post_rst_data", out_data, 8'h1E);
        idle(3);

        // Randomized traffic with random consumer back-pressure.
        rand_ready = 1'b1;
        for (int fr = 0; fr < 150; fr++) begin
            int len;
            len = ($urandom_range(0, 4) != 0) ? NF : int'($urandom_range(1, 7));
            for (int i = 0; i < len; i++) begin
                int v;
                v = ($urandom_range(0, 1) != 0) ? picks[$urandom_range(0, 7)]
                                                : int'($signed(8'($urandom_range(0, 255))));
                send_beat(v, (i == len - 1));
                if ($urandom_range(0, 4) == 0) idle(int'($urandom_range(1, 2)));
            end
        end
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        idle(10);
        chk("all_frames_delivered", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
